// File: rtl/soc_system_pio_clock_cmd_pkg.sv
// rtl/soc_system_pio_clock_cmd_pkg.sv - register offsets, status bits and handshake state for the clock command PIO
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int ST_PEND = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/soc_system_pio_clock_cmd_if.sv
// rtl/soc_system_pio_clock_cmd_if.sv - Avalon-MM register port of the clock command PIO
interface soc_system_pio_clock_cmd_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_pio_clock_cmd.sv
// rtl/soc_system_pio_clock_cmd.sv - HPS-written chess-clock command PIO with valid/ack handshake and sticky status
module soc_system_pio_clock_cmd
  import soc_system_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  soc_system_pio_clock_cmd_if.slave avs,
  output logic [DATA_WIDTH-1:0]     out_port,
  output logic                      cmd_valid,
  input  logic                      cmd_ack,
  output logic                      irq
);

  cmd_state_e            state, state_next;
  logic                  done_q, ovr_q;
  logic [1:0]            irq_mask;
  logic [DATA_WIDTH-1:0] wd;
  logic                  wr, wr_data, wr_set, wr_clr, wr_status, wr_mask, cmd_wr;
  logic                  done_set, ovr_set;
  logic [31:0]           rd_mux;

  assign wd        = avs.writedata[DATA_WIDTH-1:0];
  assign wr        = avs.chipselect & ~avs.write_n;
  assign wr_data   = wr & (avs.address == ADDR_DATA);
  assign wr_set    = wr & (avs.address == ADDR_OUTSET);
  assign wr_clr    = wr & (avs.address == ADDR_OUTCLR);
  assign wr_status = wr & (avs.address == ADDR_STATUS);
  assign wr_mask   = wr & (avs.address == ADDR_IRQMASK);
  assign cmd_wr    = wr_data | wr_set | wr_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A new command in the ack cycle keeps the handshake open for the new word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_wr) state_next = PEND;
      PEND:    if (cmd_ack && !cmd_wr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == PEND);
    done_set  = (state == PEND) & cmd_ack;
    ovr_set   = (state == PEND) & cmd_wr & ~cmd_ack;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else if (wr_data) begin
      out_port <= wd;
    end else if (wr_set) begin
      out_port <= out_port | wd;
    end else if (wr_clr) begin
      out_port <= out_port & ~wd;
    end
  end

  // Set events take priority over a W1C in the same cycle so no completion is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_mask <= 2'b00;
    end else begin
      if (done_set)                                 done_q <= 1'b1;
      else if (wr_status && avs.writedata[ST_DONE]) done_q <= 1'b0;
      if (ovr_set)                                  ovr_q  <= 1'b1;
      else if (wr_status && avs.writedata[ST_OVR])  ovr_q  <= 1'b0;
      if (wr_mask) irq_mask <= avs.writedata[2:1];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      ADDR_DATA: rd_mux = 32'(out_port);
      ADDR_STATUS: begin
        rd_mux[ST_PEND] = cmd_valid;
        rd_mux[ST_DONE] = done_q;
        rd_mux[ST_OVR]  = ovr_q;
      end
      ADDR_IRQMASK: rd_mux[2:1] = irq_mask;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      avs.readdata <= rd_mux;
      irq          <= |({ovr_q, done_q} & irq_mask);
    end
  end

endmodule
